// File: rtl/vc_arbiter.sv
// Two-VC to two-destination arbiter: VC0 priority, per-word destination routing, one-cycle push pipeline.
// Optional VC1 anti-starvation burst guard enabled by defining VC_ARB_STARVE_GUARD_EN.
module vc_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    output logic                  vc0_pop,
    output logic                  vc1_pop,
    output logic                  d0_push,
    output logic                  d1_push,
    output logic [DATA_WIDTH-1:0] d0_data,
    output logic [DATA_WIDTH-1:0] d1_data,
    output logic [1:0]            arb_state
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_GNT0 = 2'd2,
        ST_GNT1 = 2'd3
    } arb_state_t;

    arb_state_t r_state;
    arb_state_t w_next_state;

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_guard;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  w_any_grant;
    logic [DATA_WIDTH-1:0] w_word;
    logic                  w_word_dest;

    logic                  r_d0_push;
    logic                  r_d1_push;
    logic [DATA_WIDTH-1:0] r_d0_data;
    logic [DATA_WIDTH-1:0] r_d1_data;

    // Eligibility looks at the almost-full flag of the FIFO each head word is bound for.
    assign w_elig0 = !vc0_empty && !(vc0_data[DATA_WIDTH-1] ? d1_almost_full : d0_almost_full);
    assign w_elig1 = !vc1_empty && !(vc1_data[DATA_WIDTH-1] ? d1_almost_full : d0_almost_full);

`ifdef VC_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX);

    logic [CNT_W-1:0] r_burst;

    assign w_guard = (r_burst == BURST_LIM) && w_elig1;

    // Burst counter: counts VC0 wins that held off an eligible VC1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_burst <= {CNT_W{1'b0}};
        end else if (w_grant1) begin
            r_burst <= {CNT_W{1'b0}};
        end else if (w_grant0 && w_elig1) begin
            r_burst <= r_burst + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_burst <= r_burst;
        end
    end
`else
    assign w_guard = 1'b0;
`endif

    assign w_grant1    = active && (w_guard || (!w_elig0 && w_elig1));
    assign w_grant0    = active && w_elig0 && !w_guard;
    assign w_any_grant = w_grant0 || w_grant1;
    assign w_word      = w_grant0 ? vc0_data : vc1_data;
    assign w_word_dest = w_word[DATA_WIDTH-1];

    // Next-state decode from the current grant decision.
    always_comb begin
        w_next_state = ST_OFF;
        if (!active) begin
            w_next_state = ST_OFF;
        end else if (w_grant0) begin
            w_next_state = ST_GNT0;
        end else if (w_grant1) begin
            w_next_state = ST_GNT1;
        end else begin
            w_next_state = ST_WAIT;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Push pipeline: popped word lands on its destination one cycle later; data holds otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_d0_push <= 1'b0;
            r_d1_push <= 1'b0;
            r_d0_data <= {DATA_WIDTH{1'b0}};
            r_d1_data <= {DATA_WIDTH{1'b0}};
        end else begin
            r_d0_push <= w_any_grant && !w_word_dest;
            r_d1_push <= w_any_grant && w_word_dest;
            if (w_any_grant && !w_word_dest) begin
                r_d0_data <= w_word;
            end else begin
                r_d0_data <= r_d0_data;
            end
            if (w_any_grant && w_word_dest) begin
                r_d1_data <= w_word;
            end else begin
                r_d1_data <= r_d1_data;
            end
        end
    end

    assign vc0_pop   = w_grant0;
    assign vc1_pop   = w_grant1;
    assign d0_push   = r_d0_push;
    assign d1_push   = r_d1_push;
    assign d0_data   = r_d0_data;
    assign d1_data   = r_d1_data;
    assign arb_state = r_state;

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed self-checking bench for vc_arbiter (default build, or guard build when VC_ARB_STARVE_GUARD_EN is defined).
module tb_vc_arbiter;

    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          active = 1'b0;
    logic          vc0_empty = 1'b1;
    logic          vc1_empty = 1'b1;
    logic [DW-1:0] vc0_data = 6'b000000;
    logic [DW-1:0] vc1_data = 6'b000000;
    logic          d0_almost_full = 1'b0;
    logic          d1_almost_full = 1'b0;
    logic          vc0_pop, vc1_pop, d0_push, d1_push;
    logic [DW-1:0] d0_data, d1_data;
    logic [1:0]    arb_state;

    int total = 0;
    int bad = 0;

    vc_arbiter #(.DATA_WIDTH(DW), .BURST_MAX(4)) dut (
        .clk(clk), .reset(reset), .active(active),
        .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .vc0_data(vc0_data), .vc1_data(vc1_data),
        .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
        .vc0_pop(vc0_pop), .vc1_pop(vc1_pop),
        .d0_push(d0_push), .d1_push(d1_push),
        .d0_data(d0_data), .d1_data(d1_data),
        .arb_state(arb_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        total++; if ({vc0_pop, vc1_pop, d0_push, d1_push} !== 4'b0000) begin bad++; $display("FAIL reset_strobes got=%b want=0000", {vc0_pop, vc1_pop, d0_push, d1_push}); end
        total++; if ({d0_data, d1_data, arb_state} !== 14'd0) begin bad++; $display("FAIL reset_data got=%h want=0", {d0_data, d1_data, arb_state}); end
        tick();
        reset = 1'b1;
        tick();
        // start traffic then reset with a push in flight
        active = 1'b1; vc0_empty = 1'b0; vc0_data = 6'b000110;
        #1;
        total++; if (vc0_pop !== 1'b1) begin bad++; $display("FAIL pre_reset_pop got=%b want=1", vc0_pop); end
        tick();
        active = 1'b0; vc0_empty = 1'b1;
        total++; if (d0_push !== 1'b1) begin bad++; $display("FAIL inflight_push got=%b want=1", d0_push); end
        #2 reset = 1'b0;
        #1;
        total++; if ({d0_push, d1_push, d0_data, arb_state} !== 9'd0) begin bad++; $display("FAIL async_flush got=%h want=0", {d0_push, d1_push, d0_data, arb_state}); end
        tick();
        reset = 1'b1;
        vc0_empty = 1'b0; vc0_data = 6'b000001;
        #1;
        total++; if (vc0_pop !== 1'b0) begin bad++; $display("FAIL pop_while_inactive got=%b want=0", vc0_pop); end
        tick();
        active = 1'b1;
        #1;
        total++; if (vc0_pop !== 1'b1) begin bad++; $display("FAIL first_pop_after_active got=%b want=1", vc0_pop); end
        tick();
        active = 1'b0; vc0_empty = 1'b1;
        tick();
    endtask

    task automatic test_routing();
        active = 1'b1; vc0_empty = 1'b0; vc0_data = 6'b100011;
        #1;
        total++; if ({vc0_pop, vc1_pop, d1_push} !== 3'b100) begin bad++; $display("FAIL route_pop1 got=%b want=100", {vc0_pop, vc1_pop, d1_push}); end
        tick();
        total++; if ({d1_push, d0_push} !== 2'b10 || d1_data !== 6'b100011) begin bad++; $display("FAIL route_d1 got=%b/%b want=10/100011", {d1_push, d0_push}, d1_data); end
        total++; if (arb_state !== 2'd2) begin bad++; $display("FAIL route_state got=%0d want=2", arb_state); end
        vc0_data = 6'b000101;
        #1;
        total++; if (vc0_pop !== 1'b1) begin bad++; $display("FAIL route_pop2 got=%b want=1", vc0_pop); end
        tick();
        vc0_empty = 1'b1;
        total++; if ({d0_push, d1_push} !== 2'b10 || d0_data !== 6'b000101 || d1_data !== 6'b100011) begin bad++; $display("FAIL route_d0 got=%b/%b/%b want=10/000101/100011", {d0_push, d1_push}, d0_data, d1_data); end
        tick();
        total++; if ({d0_push, d1_push} !== 2'b00 || d0_data !== 6'b000101) begin bad++; $display("FAIL route_hold got=%b/%b want=00/000101", {d0_push, d1_push}, d0_data); end
        tick();
        total++; if (arb_state !== 2'd1) begin bad++; $display("FAIL route_wait got=%0d want=1", arb_state); end
    endtask

    task automatic test_priority();
        logic [9:0] got;
        logic [9:0] want;
        active = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b0;
        vc0_data = 6'b000010; vc1_data = 6'b000100;
`ifdef VC_ARB_STARVE_GUARD_EN
        want = 10'b1000010000; // bit i = VC1 granted in cycle i (LSB first)
`else
        want = 10'b0000000000;
`endif
        got = 10'd0;
        for (int i = 0; i < 10; i++) begin
            #1;
            total++; if ((vc0_pop ^ vc1_pop) !== 1'b1) begin bad++; $display("FAIL prio_onehot cyc=%0d got=%b%b want one-hot", i, vc0_pop, vc1_pop); end
            got[i] = vc1_pop;
            tick();
            total++; if (arb_state !== (want[i] ? 2'd3 : 2'd2)) begin bad++; $display("FAIL prio_state cyc=%0d got=%0d want=%0d", i, arb_state, want[i] ? 3 : 2); end
            total++; if (d0_data !== (want[i] ? 6'b000100 : 6'b000010)) begin bad++; $display("FAIL prio_data cyc=%0d got=%b", i, d0_data); end
        end
        total++; if (got !== want) begin bad++; $display("FAIL prio_pattern got=%b want=%b", got, want); end
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        active = 1'b1; vc0_empty = 1'b0; vc1_empty = 1'b0;
        d1_almost_full = 1'b1; vc0_data = 6'b100001; vc1_data = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({vc0_pop, vc1_pop} !== 2'b01) begin bad++; $display("FAIL bp_hol cyc=%0d got=%b want=01", i, {vc0_pop, vc1_pop}); end
            tick();
            total++; if ({d0_push, d1_push} !== 2'b10 || d0_data !== 6'b000010) begin bad++; $display("FAIL bp_push cyc=%0d got=%b/%b want=10/000010", i, {d0_push, d1_push}, d0_data); end
        end
        d1_almost_full = 1'b0;
        #1;
        total++; if ({vc0_pop, vc1_pop} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b want=10", {vc0_pop, vc1_pop}); end
        tick();
        total++; if ({d0_push, d1_push} !== 2'b01 || d1_data !== 6'b100001) begin bad++; $display("FAIL bp_release_push got=%b/%b want=01/100001", {d0_push, d1_push}, d1_data); end
        vc0_empty = 1'b1; vc1_empty = 1'b1;
        tick();
    endtask

    task automatic test_disable();
        active = 1'b1; vc0_empty = 1'b0; vc0_data = 6'b000111;
        #1;
        total++; if (vc0_pop !== 1'b1) begin bad++; $display("FAIL dis_pop got=%b want=1", vc0_pop); end
        tick();
        active = 1'b0;
        #1;
        total++; if ({vc0_pop, vc1_pop} !== 2'b00) begin bad++; $display("FAIL dis_no_pop got=%b want=00", {vc0_pop, vc1_pop}); end
        total++; if (d0_push !== 1'b1 || d0_data !== 6'b000111 || arb_state !== 2'd2) begin bad++; $display("FAIL dis_pending got=%b/%b/%0d want=1/000111/2", d0_push, d0_data, arb_state); end
        tick();
        total++; if (arb_state !== 2'd0 || d0_push !== 1'b0 || vc0_pop !== 1'b0) begin bad++; $display("FAIL dis_off got=%0d/%b/%b want=0/0/0", arb_state, d0_push, vc0_pop); end
        vc0_empty = 1'b1;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_priority();
        test_backpressure();
        test_disable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vc_arbiter.md
# vc_arbiter

- Drains the two virtual-channel FIFOs (VC0, VC1) and routes each word to destination FIFO D0 or D1, chosen by the word's destination bit.
- Sits between the VC FIFOs and the D FIFOs and is gated by the control FSM's `active` output.
- VC0 has priority over VC1. An optional anti-starvation guard forces a VC1 grant after a bounded run of VC0 grants.
- Backpressure comes from the D FIFOs' almost-full flags, which the control FSM configures from the D0/D1 thresholds.

## Interface
Parameters:
- `DATA_WIDTH`, 6: FIFO word width. Bit `[DATA_WIDTH-1]` is the destination (0 = D0, 1 = D1).
- `BURST_MAX`, 4: consecutive VC0 grants allowed while VC1 is eligible (guard only). Range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `active`  in  1  enable from the control FSM; 0 blocks new grants.
- `vc0_empty`, `vc1_empty`  in  1 each  VC FIFO empty flags.
- `vc0_data`, `vc1_data`  in  `DATA_WIDTH` each  VC FIFO head words (first-word-fall-through; valid while not empty).
- `d0_almost_full`, `d1_almost_full`  in  1 each  destination backpressure.
- `vc0_pop`, `vc1_pop`  out  1 each  combinational pop strobes.
- `d0_push`, `d1_push`  out  1 each  registered push strobes.
- `d0_data`, `d1_data`  out  `DATA_WIDTH` each  registered push data.
- `arb_state`  out  2  current state: 0 OFF, 1 WAIT, 2 GNT0, 3 GNT1.

## Operation
Eligibility:
- `eligX = !vcX_empty && !dN_almost_full`, where N is bit `[DATA_WIDTH-1]` of `vcX_data`.

Grant selection (combinational, evaluated only when `active=1`):
- If the guard condition holds (see Configuration), grant VC1.
- Otherwise, if `elig0`, grant VC0.
- Otherwise, if `elig1`, grant VC1.
- Otherwise, no grant.
- At most one of `vc0_pop` and `vc1_pop` is high in any cycle.

State machine (one register, updated every cycle):
- Next state is OFF if `active=0`.
- Otherwise GNT0 or GNT1 if the respective grant fired this cycle, or WAIT if there was no grant.
- `arb_state` reflects the registered state, i.e. the previous cycle's decision.

Push pipeline:
- The granted head word is captured at the rising edge of the pop cycle.
- In the next cycle the matching `dN_push` is asserted and the word appears on `dN_data`.
- Exactly one push occurs per pop; words are never duplicated or reordered within a VC.

Data outputs:
- `d0_data` and `d1_data` hold their last value when not pushing.

Backpressure:
- The D FIFOs must assert almost-full with at least 1 free slot remaining, to absorb the in-flight push.
- The arbiter does not re-check fullness at push time.

Boundary conditions:
- Both VCs eligible, VC0 and VC1 heads going to the same D: VC0 wins (guard aside).
- Heads going to different D FIFOs: still one grant per cycle. Throughput is 1 word/cycle total.
- VC0 head blocked by backpressure, VC1 head eligible: VC1 is granted, so head-of-line blocking does not cross channels.
- `active` falls: no pop in that cycle. A push already in flight from the previous pop still completes.
- `reset` asserted mid-operation: the in-flight push is dropped. Upstream must treat reset as a full flush.

## Timing
- Reset values: all pops, pushes and `dN_data` are 0, `arb_state`=0 (OFF), burst counter 0.
- Pop strobes are combinational from the current inputs, registered state and counter.
- Pop-to-push latency: 1 cycle.
- `active` rising at edge k: first pop possible in cycle k+1, once the synchronously sampled `active` is seen (`active` is treated as a registered FSM output).
- Async reset clears everything immediately. Release is sampled at the next `clk` edge.

## Configuration
Macro `VC_ARB_STARVE_GUARD_EN`:
- Defined: a burst counter of `$clog2(BURST_MAX+1)` bits.
  - Increments on each VC0 grant while `elig1=1`.
  - Clears on each VC1 grant.
  - Holds otherwise.
  - When the counter equals `BURST_MAX` and `elig1=1`, VC1 is granted even if `elig0=1`.
- Undefined: no counter; strict VC0 priority, so VC1 can starve.

## Test plan
- Reset and flush:
  - Stimulus: `reset=0` during traffic.
  - Required: all outputs 0 and `arb_state`=0 immediately. After `reset=1`, `active=1` and data in VC0, the first pop occurs one cycle later.
- Routing:
  - Stimulus: VC0 holds 6'b100011 then 6'b000101, D FIFOs not full.
  - Required: `d1_push` carries 6'b100011, next cycle `d0_push` carries 6'b000101. Push lags pop by 1 cycle.
- Priority:
  - Stimulus: both VCs continuously non-empty, guard macro undefined.
  - Required: only `vc0_pop` fires; `arb_state` stays 2.
- Starvation guard:
  - Stimulus: guard defined, `BURST_MAX`=4, both VCs non-empty.
  - Required: grant pattern 0,0,0,0,1,0,0,0,0,1...
- Backpressure:
  - Stimulus: `d1_almost_full=1`, VC0 head destined to D1, VC1 head destined to D0.
  - Required: `vc1_pop` fires and `vc0_pop`=0 until `d1_almost_full` drops.
- Disable:
  - Stimulus: `active` set 0 one cycle after a pop.
  - Required: the pending push still completes; no further pops; `arb_state`=0 the following cycle.
